ex_mem_stage: RTL and testbench

Parametrised EX/MEM pipeline register that supersedes the fixed-field latch. It carries a packed payload and control word plus a valid bit, and supports stall and flush. It owns the data-memory request as a small FSM: the request is held until dhit, the load data is captured, and upstream is frozen while the request is outstanding. It sits between the execute stage and the MEM/WB latch, and drives the datapath side of the memory interface.

---
 rtl/ex_mem_stage.sv | 192 +++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register that owns the data-memory request.
// Optional perf counters: define EX_MEM_STAGE_PERF_CNT_EN.
module ex_mem_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int PAYLOAD_W = 128,
  parameter int CTRL_W    = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 stall_in,
  input  logic                 flush_in,
  input  logic                 valid_in,
  input  logic [CTRL_W-1:0]    ctrl_in,
  input  logic [PAYLOAD_W-1:0] data_in,
  input  logic                 halt_in,
  input  logic                 dmemREN_in,
  input  logic                 dmemWEN_in,
  input  logic [ADDR_W-1:0]    dmemaddr_in,
  input  logic [DATA_W-1:0]    dmemstore_in,
  input  logic                 dhit,
  input  logic [DATA_W-1:0]    dmemload,
  output logic                 valid_out,
  output logic [CTRL_W-1:0]    ctrl_out,
  output logic [PAYLOAD_W-1:0] data_out,
  output logic                 halt_out,
  output logic                 dmemREN,
  output logic                 dmemWEN,
  output logic [ADDR_W-1:0]    dmemaddr,
  output logic [DATA_W-1:0]    dmemstore,
  output logic [DATA_W-1:0]    load_data,
  output logic                 mem_stall
`ifdef EX_MEM_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]          mem_wait_cnt,
  output logic [31:0]          stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 r_valid;
  logic [CTRL_W-1:0]    r_ctrl;
  logic [PAYLOAD_W-1:0] r_data;
  logic                 r_halt;
  logic                 r_ren;
  logic                 r_wen;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_store;
  logic [DATA_W-1:0]    r_load_q;

  logic w_in_req;
  logic w_mem_stall;
  logic w_adv;
  logic w_ren_cap;
  logic w_wen_cap;
  logic w_req_cap;
  logic w_hit;

  // Handshake terms: stall while the bus request waits, advance otherwise
  always_comb begin
    w_in_req    = (r_state == S_REQ);
    w_mem_stall = w_in_req && !dhit;
    w_hit       = w_in_req && dhit;
    w_adv       = !w_mem_stall && (flush_in || !stall_in);
    w_wen_cap   = valid_in && dmemWEN_in;
    w_ren_cap   = valid_in && dmemREN_in && !dmemWEN_in;
    w_req_cap   = !flush_in && (w_ren_cap || w_wen_cap);
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a completing request either retires or parks in DONE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_adv) begin
          w_state_nxt = w_req_cap ? S_REQ : S_IDLE;
        end
      end
      S_REQ: begin
        if (w_adv) begin
          w_state_nxt = w_req_cap ? S_REQ : S_IDLE;
        end else if (dhit) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pipeline fields: bubble on flush, capture on advance, else hold
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
      r_halt  <= 1'b0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_store <= '0;
    end else if (w_adv) begin
      if (flush_in) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        r_data  <= '0;
        r_halt  <= 1'b0;
        r_ren   <= 1'b0;
        r_wen   <= 1'b0;
        r_addr  <= '0;
        r_store <= '0;
      end else begin
        r_valid <= valid_in;
        r_ctrl  <= ctrl_in;
        r_data  <= data_in;
        r_halt  <= halt_in;
        r_ren   <= w_ren_cap;
        r_wen   <= w_wen_cap;
        r_addr  <= dmemaddr_in;
        r_store <= dmemstore_in;
      end
    end
  end

  // Keep the returned word so it survives while the entry is held
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_load_q <= '0;
    end else if (w_hit) begin
      r_load_q <= dmemload;
    end
  end

  // FSM outputs: requests only while on the bus, load data bypassed in REQ
  always_comb begin
    valid_out = r_valid;
    ctrl_out  = r_ctrl;
    data_out  = r_data;
    halt_out  = r_halt;
    dmemaddr  = r_addr;
    dmemstore = r_store;
    dmemREN   = r_ren && w_in_req;
    dmemWEN   = r_wen && w_in_req;
    load_data = w_in_req ? dmemload : r_load_q;
    mem_stall = w_mem_stall;
  end

`ifdef EX_MEM_STAGE_PERF_CNT_EN
  logic [31:0] r_mem_wait_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall_evt;

  // Only count stalls that actually freeze the stage from upstream
  always_comb begin
    w_stall_evt  = stall_in && !flush_in && !w_mem_stall;
    mem_wait_cnt = r_mem_wait_cnt;
    stall_cnt    = r_stall_cnt;
  end

  // Saturating event counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mem_wait_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (w_mem_stall && (r_mem_wait_cnt != 32'hFFFF_FFFF)) begin
        r_mem_wait_cnt <= r_mem_wait_cnt + 32'd1;
      end
      if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: random + directed bench for ex_mem_stage.
// Behavioural entry/pending model compared every cycle.
module tb_ex_mem_stage;

  logic         CLK = 1'b0;
  logic         RST;
  logic         stall_in, flush_in, valid_in;
  logic [7:0]   ctrl_in;
  logic [127:0] data_in;
  logic         halt_in, dmemREN_in, dmemWEN_in;
  logic [31:0]  dmemaddr_in, dmemstore_in;
  logic         dhit;
  logic [31:0]  dmemload;
  logic         valid_out;
  logic [7:0]   ctrl_out;
  logic [127:0] data_out;
  logic         halt_out, dmemREN, dmemWEN;
  logic [31:0]  dmemaddr, dmemstore, load_data;
  logic         mem_stall;
`ifdef EX_MEM_STAGE_PERF_CNT_EN
  logic [31:0]  mem_wait_cnt, stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ex_mem_stage dut (
    .CLK(CLK), .RST(RST),
    .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .ctrl_in(ctrl_in),
    .data_in(data_in), .halt_in(halt_in),
    .dmemREN_in(dmemREN_in), .dmemWEN_in(dmemWEN_in),
    .dmemaddr_in(dmemaddr_in),
    .dmemstore_in(dmemstore_in),
    .dhit(dhit), .dmemload(dmemload),
    .valid_out(valid_out), .ctrl_out(ctrl_out),
    .data_out(data_out), .halt_out(halt_out),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .load_data(load_data), .mem_stall(mem_stall)
`ifdef EX_MEM_STAGE_PERF_CNT_EN
    ,
    .mem_wait_cnt(mem_wait_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h",
               nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic         valid;
    logic [7:0]   ctrl;
    logic [127:0] data;
    logic         halt;
    logic         ren;
    logic         wen;
    logic [31:0]  addr;
    logic [31:0]  store;
  } ent_t;

  ent_t        m_e;
  bit          m_pend = 0;
  logic [31:0] m_lq;
  bit          m_live = 0;
  longint      m_wait = 0;
  longint      m_stl = 0;

  always @(posedge CLK) begin
    bit blocked;
    bit go;
    if (RST) begin
      m_e = '0;
      m_pend = 0;
      m_lq = '0;
      m_wait = 0;
      m_stl = 0;
      m_live = 1;
    end else begin
      blocked = m_pend && !dhit;
      if (blocked) m_wait = m_wait + 1;
      if (stall_in && !flush_in && !blocked) m_stl = m_stl + 1;
      if (m_wait > 64'hFFFF_FFFF) m_wait = 64'hFFFF_FFFF;
      if (m_stl > 64'hFFFF_FFFF) m_stl = 64'hFFFF_FFFF;
      if (m_pend && dhit) m_lq = dmemload;
      go = !blocked && (flush_in || !stall_in);
      if (go) begin
        if (flush_in) begin
          m_e = '0;
        end else begin
          m_e.valid = valid_in;
          m_e.ctrl  = ctrl_in;
          m_e.data  = data_in;
          m_e.halt  = halt_in;
          m_e.wen   = valid_in && dmemWEN_in;
          m_e.ren   = valid_in && dmemREN_in && !dmemWEN_in;
          m_e.addr  = dmemaddr_in;
          m_e.store = dmemstore_in;
        end
        m_pend = m_e.ren || m_e.wen;
      end else if (m_pend && dhit) begin
        m_pend = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge CLK) begin
    if (m_live) begin
      chk("m.valid", 128'(valid_out), 128'(m_e.valid));
      chk("m.ctrl", 128'(ctrl_out), 128'(m_e.ctrl));
      chk("m.data", data_out, m_e.data);
      chk("m.halt", 128'(halt_out), 128'(m_e.halt));
      chk("m.addr", 128'(dmemaddr), 128'(m_e.addr));
      chk("m.store", 128'(dmemstore), 128'(m_e.store));
      chk("m.ren", 128'(dmemREN), 128'(m_pend && m_e.ren));
      chk("m.wen", 128'(dmemWEN), 128'(m_pend && m_e.wen));
      chk("m.mstall", 128'(mem_stall), 128'(m_pend && !dhit));
      chk("m.ldata", 128'(load_data),
          128'(m_pend ? dmemload : m_lq));
`ifdef EX_MEM_STAGE_PERF_CNT_EN
      chk("m.wcnt", 128'(mem_wait_cnt), 128'(m_wait));
      chk("m.scnt", 128'(stall_cnt), 128'(m_stl));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_in();
    stall_in = 0; flush_in = 0; valid_in = 0;
    ctrl_in = '0; data_in = '0; halt_in = 0;
    dmemREN_in = 0; dmemWEN_in = 0;
    dmemaddr_in = '0; dmemstore_in = '0;
    dhit = 0; dmemload = '0;
  endtask

  task automatic rand_in();
    stall_in     = ($urandom_range(0, 3) == 0);
    flush_in     = ($urandom_range(0, 7) == 0);
    valid_in     = ($urandom_range(0, 3) != 0);
    ctrl_in      = 8'($urandom());
    data_in      = {$urandom(), $urandom(),
                    $urandom(), $urandom()};
    halt_in      = ($urandom_range(0, 15) == 0);
    dmemREN_in   = ($urandom_range(0, 4) < 2);
    dmemWEN_in   = ($urandom_range(0, 4) < 2);
    dmemaddr_in  = $urandom();
    dmemstore_in = $urandom();
    dhit         = ($urandom_range(0, 4) < 2);
    dmemload     = $urandom();
  endtask

  initial begin
    int rcnt;
    clear_in();
    RST = 1;
    rand_in();
    step();
    rand_in();
    step();
    #1;
    chk("rst.valid", 128'(valid_out), 128'd0);
    chk("rst.data", data_out, 128'd0);
    chk("rst.ctrl", 128'(ctrl_out), 128'd0);
    chk("rst.req", 128'({dmemREN, dmemWEN}), 128'd0);
    chk("rst.mstall", 128'(mem_stall), 128'd0);
    chk("rst.ldata", 128'(load_data), 128'd0);

    clear_in();
    RST = 0;
    valid_in = 1;
    data_in = {16{8'hA5}};
    step();
    chk("pass.data", data_out, {16{8'hA5}});
    chk("pass.valid", 128'(valid_out), 128'd1);

    // load with three request cycles, dhit in the third
    clear_in();
    valid_in = 1;
    dmemREN_in = 1;
    dmemaddr_in = 32'h0000_0040;
    step();
    clear_in();
    rcnt = 0;
    #1;
    if (dmemREN) rcnt++;
    chk("ld.mstall1", 128'(mem_stall), 128'd1);
    chk("ld.addr", 128'(dmemaddr), 128'h40);
    step();
    if (dmemREN) rcnt++;
    chk("ld.mstall2", 128'(mem_stall), 128'd1);
    step();
    dhit = 1;
    dmemload = 32'hDEAD_BEEF;
    #1;
    if (dmemREN) rcnt++;
    chk("ld.mstall3", 128'(mem_stall), 128'd0);
    chk("ld.ldata", 128'(load_data), 128'hDEAD_BEEF);
    step();
    clear_in();
    #1;
    chk("ld.rendrop", 128'(dmemREN), 128'd0);
    chk("ld.rencnt", 128'(rcnt), 128'd3);
    chk("ld.adv", 128'(valid_out), 128'd0);

    // store completes while stalled
    clear_in();
    valid_in = 1;
    dmemWEN_in = 1;
    dmemaddr_in = 32'h80;
    dmemstore_in = 32'h1234;
    step();
    clear_in();
    #1;
    chk("st.wen", 128'(dmemWEN), 128'd1);
    chk("st.store", 128'(dmemstore), 128'h1234);
    stall_in = 1;
    dhit = 1;
    dmemload = 32'hCAFE_F00D;
    step();
    clear_in();
    stall_in = 1;
    dmemload = 32'h1111_1111;
    #1;
    chk("st.wendrop", 128'(dmemWEN), 128'd0);
    chk("st.lheld", 128'(load_data), 128'hCAFE_F00D);
    chk("st.hold", 128'(valid_out), 128'd1);
    step();
    chk("st.noreq", 128'(dmemWEN), 128'd0);
    clear_in();
    valid_in = 1;
    ctrl_in = 8'h5A;
    step();
    chk("st.next", 128'(ctrl_out), 128'h5A);
    chk("st.nore", 128'({dmemREN, dmemWEN}), 128'd0);

    // flush beats stall
    clear_in();
    flush_in = 1;
    stall_in = 1;
    valid_in = 1;
    ctrl_in = 8'hFF;
    step();
    chk("fl.valid", 128'(valid_out), 128'd0);
    chk("fl.ctrl", 128'(ctrl_out), 128'd0);

    // flush ignored during a request wait
    clear_in();
    valid_in = 1;
    dmemREN_in = 1;
    ctrl_in = 8'h33;
    step();
    clear_in();
    flush_in = 1;
    #1;
    chk("flq.mstall", 128'(mem_stall), 128'd1);
    step();
    chk("flq.hold", 128'(ctrl_out), 128'h33);
    chk("flq.ren", 128'(dmemREN), 128'd1);
    dhit = 1;
    step();
    clear_in();
    chk("flq.done", 128'(valid_out), 128'd0);
    chk("flq.rdone", 128'(dmemREN), 128'd0);

    // write wins over read; invalid entry never requests
    clear_in();
    valid_in = 1;
    dmemREN_in = 1;
    dmemWEN_in = 1;
    step();
    clear_in();
    chk("both.req", 128'({dmemREN, dmemWEN}), 128'b01);
    dhit = 1;
    dmemREN_in = 1;
    dmemWEN_in = 1;
    step();
    clear_in();
    chk("inv.req", 128'({dmemREN, dmemWEN}), 128'd0);
    chk("inv.mstall", 128'(mem_stall), 128'd0);

`ifdef EX_MEM_STAGE_PERF_CNT_EN
    clear_in();
    RST = 1;
    step();
    RST = 0;
    valid_in = 1;
    dmemREN_in = 1;
    step();
    clear_in();
    repeat (5) step();
    dhit = 1;
    step();
    clear_in();
    stall_in = 1;
    repeat (4) step();
    clear_in();
    chk("pc.wait", 128'(mem_wait_cnt), 128'd5);
    chk("pc.stall", 128'(stall_cnt), 128'd4);
    RST = 1;
    step();
    RST = 0;
    chk("pc.rst", 128'({mem_wait_cnt, stall_cnt}), 128'd0);
`endif

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      RST = ($urandom_range(0, 63) == 0);
      step();
    end
    clear_in();
    RST = 0;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
